// File: rtl/clock_meter_pkg.sv
// Shared types and width helper for the clock_meter block.
package clock_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cm_state_e;

  // Number of bits needed to hold values 0..max_val, never less than 1.
  function automatic int cm_width(input longint unsigned max_val);
    int w;
    w = 1;
    while (w < 63 && (64'd1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronously reset to 0.
module sync_2ff (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clock_meter.sv
// Frequency / period / stall monitor for a slow asynchronous clock-like input,
// measured in clk_in cycles.
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter  int GATE_CYCLES = 50_000_000,
  parameter  int TIMEOUT     = 100_000_000,
  localparam int CNT_W       = cm_width(longint'(GATE_CYCLES)),
  localparam int PER_W       = cm_width(longint'(TIMEOUT))
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic [PER_W-1:0] period_out,
  output logic             period_valid,
  output logic             stall_out
);

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EDGE_MAX  = '1;
  localparam logic [PER_W-1:0] PER_MAX   = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0] PER_STALL = PER_W'(TIMEOUT - 1);

  logic             sig_sync;
  logic             sig_d_q;
  logic             rise;

  cm_state_e        state_q, state_d;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] edge_sum;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             armed_q, armed_d;
  logic             stall_q, stall_d;
  logic             fv_q, fv_d;
  logic             pv_q, pv_d;

  sync_2ff u_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_i    (sig_in),
    .q_o    (sig_sync)
  );

  // sig_d_q runs in every state so entering RUN with sig high is not a rise.
  assign rise     = sig_sync & ~sig_d_q;
  assign edge_sum = (edge_cnt_q == EDGE_MAX) ? edge_cnt_q : edge_cnt_q + CNT_W'(rise);

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    per_cnt_d  = per_cnt_q;
    armed_d    = armed_q;
    stall_d    = stall_q;
    freq_d     = freq_q;
    period_d   = period_q;
    fv_d       = 1'b0;
    pv_d       = 1'b0;

    if (!en_in || state_q == IDLE) begin
      state_d    = en_in ? RUN : IDLE;
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      per_cnt_d  = '0;
      armed_d    = 1'b0;
      stall_d    = 1'b0;
    end else begin
      // Gate window: an edge landing on the last cycle belongs to the closing window.
      if (gate_cnt_q == GATE_LAST) begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        freq_d     = edge_sum;
        fv_d       = 1'b1;
      end else begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = edge_sum;
      end

      // Period / stall tracking; a rise always wins over the stall threshold.
      if (rise) begin
        if (armed_q) begin
          period_d = per_cnt_q + 1'b1;
          pv_d     = 1'b1;
        end
        per_cnt_d = '0;
        armed_d   = 1'b1;
        stall_d   = 1'b0;
      end else begin
        per_cnt_d = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
        if (per_cnt_q == PER_STALL) begin
          stall_d = 1'b1;
          armed_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      sig_d_q    <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      per_cnt_q  <= '0;
      armed_q    <= 1'b0;
      stall_q    <= 1'b0;
      freq_q     <= '0;
      period_q   <= '0;
      fv_q       <= 1'b0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_d_q    <= sig_sync;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      per_cnt_q  <= per_cnt_d;
      armed_q    <= armed_d;
      stall_q    <= stall_d;
      freq_q     <= freq_d;
      period_q   <= period_d;
      fv_q       <= fv_d;
      pv_q       <= pv_d;
    end
  end

  assign freq_out     = freq_q;
  assign freq_valid   = fv_q;
  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign stall_out    = stall_q;

endmodule

// File: tb/tb_clock_meter.sv
// Self-checking bench for clock_meter (GATE_CYCLES=100, TIMEOUT=64).
module tb_clock_meter;

  localparam int GATE = 100;
  localparam int TMO  = 64;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       en_in  = 1'b0;
  logic       sig_in = 1'b0;
  logic [6:0] freq_out;
  logic       freq_valid;
  logic [6:0] period_out;
  logic       period_valid;
  logic       stall_out;

  clock_meter #(.GATE_CYCLES(GATE), .TIMEOUT(TMO)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .en_in        (en_in),
    .sig_in       (sig_in),
    .freq_out     (freq_out),
    .freq_valid   (freq_valid),
    .period_out   (period_out),
    .period_valid (period_valid),
    .stall_out    (stall_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in absolute clock-edge numbers: a level change captured at edge k
  // takes effect at edge k+2 (third edge seeing the new level).
  int  cyc = 0, run_start = 0, last_ref = 0, last_rise = 0;
  bit  prev_en = 0, last_sig = 0, have_rise = 0;
  int  pend[$];
  int  win[$];
  int  exp_freq = 0, exp_per = 0;
  bit  exp_fv = 0, exp_pv = 0, exp_stall = 0;

  initial forever begin
    @(posedge clk_in or posedge rst_in);
    if (rst_in) begin
      prev_en = 0; last_sig = 0; have_rise = 0;
      pend.delete(); win.delete();
      exp_freq = 0; exp_per = 0; exp_fv = 0; exp_pv = 0; exp_stall = 0;
    end else begin
      bit rise_now;
      cyc++;
      rise_now = 0;
      if (pend.size() > 0 && pend[0] == cyc) begin
        rise_now = 1;
        void'(pend.pop_front());
      end
      if (sig_in && !last_sig) pend.push_back(cyc + 2);
      last_sig = sig_in;
      exp_fv = 0;
      exp_pv = 0;
      if (!(en_in && prev_en)) begin
        exp_stall = 0; have_rise = 0; win.delete();
        run_start = cyc; last_ref = cyc;
      end else begin
        if (rise_now) begin
          if (have_rise && cyc - last_rise <= TMO) begin
            exp_per = cyc - last_rise;
            exp_pv  = 1;
          end
          have_rise = 1; last_rise = cyc; last_ref = cyc;
          win.push_back(cyc);
        end
        if ((cyc - run_start) % GATE == 0) begin
          int n;
          n = 0;
          foreach (win[i]) if (win[i] > cyc - GATE) n++;
          exp_freq = n;
          exp_fv   = 1;
          win.delete();
        end
        exp_stall = (cyc - last_ref >= TMO);
      end
      prev_en = en_in;
    end
  end

  initial forever begin
    @(negedge clk_in);
    chk("model_freq_valid", int'(freq_valid), int'(exp_fv));
    chk("model_period_valid", int'(period_valid), int'(exp_pv));
    chk("model_stall", int'(stall_out), int'(exp_stall));
    chk("model_freq", int'(freq_out), exp_freq);
    chk("model_period", int'(period_out), exp_per);
  end

  // ---------------- stimulus helpers ----------------
  bit sq_on = 0;
  int sq_hi = 1, sq_lo = 1, sq_ph = 0;
  int tk = 0;

  task automatic tick();
    @(negedge clk_in);
    tk++;
    if (sq_on) begin
      sig_in = (sq_ph < sq_hi);
      sq_ph  = (sq_ph + 1) % (sq_hi + sq_lo);
    end
  endtask

  task automatic to_tk(input int t);
    while (tk < t) tick();
  endtask

  task automatic start_sq(input int hi, input int lo);
    sq_hi = hi; sq_lo = lo; sq_ph = hi; sq_on = 1; sig_in = 0;
  endtask

  task automatic do_reset();
    rst_in = 1; en_in = 0; sq_on = 0; sig_in = 0;
    tick(); tick();
    chk("rst_freq_out", int'(freq_out), 0);
    chk("rst_freq_valid", int'(freq_valid), 0);
    chk("rst_period_out", int'(period_out), 0);
    chk("rst_period_valid", int'(period_valid), 0);
    chk("rst_stall", int'(stall_out), 0);
    rst_in = 0;
    tick();
  endtask

  task automatic wait_fv(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!freq_valid && n < max);
  endtask

  typedef struct {
    int hi;
    int lo;
    int cycles;
    int exp_per;
    int fmin;
    int fmax;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n, pulses, hold;
    tbl[0] = '{hi: 5,  lo: 5,  cycles: 450, exp_per: 10, fmin: 10, fmax: 10};
    tbl[1] = '{hi: 4,  lo: 3,  cycles: 450, exp_per: 7,  fmin: 14, fmax: 15};
    tbl[2] = '{hi: 2,  lo: 2,  cycles: 450, exp_per: 4,  fmin: 25, fmax: 25};
    tbl[3] = '{hi: 16, lo: 16, cycles: 450, exp_per: 32, fmin: 3,  fmax: 4};
    tbl[4] = '{hi: 40, lo: 40, cycles: 450, exp_per: 0,  fmin: 1,  fmax: 2};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      start_sq(tbl[v].hi, tbl[v].lo);
      en_in = 1;
      repeat (tbl[v].cycles) tick();
      chk($sformatf("tbl%0d_period", v), int'(period_out), tbl[v].exp_per);
      chk_rng($sformatf("tbl%0d_freq", v), int'(freq_out), tbl[v].fmin, tbl[v].fmax);
    end

    // Async reset in the middle of a run, then restart.
    do_reset();
    start_sq(5, 5);
    en_in = 1;
    repeat (250) tick();
    chk("pre_rst_freq", int'(freq_out), 10);
    chk("pre_rst_period", int'(period_out), 10);
    #2 rst_in = 1;
    #1;
    chk("mid_rst_freq", int'(freq_out), 0);
    chk("mid_rst_period", int'(period_out), 0);
    chk("mid_rst_stall", int'(stall_out), 0);
    chk("mid_rst_fv", int'(freq_valid), 0);
    chk("mid_rst_pv", int'(period_valid), 0);
    tick();
    rst_in = 0;
    wait_fv(300, n);
    chk("rst_restart_latency", n, 101);
    chk("rst_restart_freq", int'(freq_out), 10);

    // Edge reaching rise on the last window cycle, and one cycle later.
    for (int late = 0; late < 2; late++) begin
      do_reset();
      en_in = 1;
      tk = 0;
      to_tk(98 + late);
      sig_in = 1;
      to_tk(101);
      chk($sformatf("lastcyc%0d_fv1", late), int'(freq_valid), 1);
      chk($sformatf("lastcyc%0d_freq1", late), int'(freq_out), late ? 0 : 1);
      to_tk(201);
      chk($sformatf("lastcyc%0d_fv2", late), int'(freq_valid), 1);
      chk($sformatf("lastcyc%0d_freq2", late), int'(freq_out), late ? 1 : 0);
    end

    // Stall timing and re-arming.
    do_reset();
    en_in = 1;
    tk = 0;
    to_tk(10); sig_in = 1;
    to_tk(13); chk("stall_first_edge_pv", int'(period_valid), 0);
    to_tk(15); sig_in = 0;
    to_tk(20); sig_in = 1;
    to_tk(23);
    chk("stall_second_edge_pv", int'(period_valid), 1);
    chk("stall_second_edge_per", int'(period_out), 10);
    to_tk(25); sig_in = 0;
    to_tk(86); chk("stall_before", int'(stall_out), 0);
    to_tk(87); chk("stall_at_64", int'(stall_out), 1);
    to_tk(100); sig_in = 1;
    to_tk(102); chk("stall_held", int'(stall_out), 1);
    to_tk(103);
    chk("stall_clear", int'(stall_out), 0);
    chk("stall_rearm_pv", int'(period_valid), 0);
    to_tk(105); sig_in = 0;
    to_tk(112); sig_in = 1;
    to_tk(115);
    chk("stall_after_pv", int'(period_valid), 1);
    chk("stall_after_per", int'(period_out), 12);

    // Enable dropped mid-window.
    do_reset();
    start_sq(5, 5);
    en_in = 1;
    tk = 0;
    to_tk(101);
    chk("en_first_fv", int'(freq_valid), 1);
    chk("en_first_freq", int'(freq_out), 10);
    to_tk(150);
    en_in = 0;
    pulses = 0;
    repeat (150) begin
      tick();
      if (freq_valid) pulses++;
    end
    chk("en_off_fv_pulses", pulses, 0);
    chk("en_off_freq_hold", int'(freq_out), 10);
    chk("en_off_period_hold", int'(period_out), 10);
    en_in = 1;
    wait_fv(300, n);
    chk("en_on_latency", n, 101);
    chk("en_on_freq", int'(freq_out), 10);

    // Randomized run against the model.
    do_reset();
    en_in = 1;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        sig_in = ~sig_in;
        hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 90))
                                            : int'($urandom_range(2, 40));
      end
      hold--;
      if ($urandom_range(0, 499) == 0) en_in = 0;
      else if (!en_in && $urandom_range(0, 29) == 0) en_in = 1;
      if (i == 1500) begin
        #3 rst_in = 1;
        #4 rst_in = 0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
